spi_master: RTL and testbench

Byte-level SPI master (mode 0, MSB first) that serves the memory controller's per-byte transaction handshake. It shifts out one byte on MOSI while capturing one byte from MISO, and signals completion over the txn_start/txn_done handshake. Chip selects are not driven here: the memory controller owns flash/RAM CE_n. The block only generates SCLK and MOSI and samples MISO.

---
 rtl/spi_master_if.sv | 20 ++
 rtl/spi_master.sv | 89 ++++++++
 tb/tb_spi_master.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Byte-transfer handshake and SPI pin bundle between an initiator and the SPI master.
interface spi_master_if;
    logic [7:0] data_tx;
    logic [7:0] data_rx;
    logic       txn_start;
    logic       txn_done;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;

    modport master (
        input  data_tx, txn_start, spi_miso,
        output data_rx, txn_done, spi_sclk, spi_mosi
    );

    modport slave (
        output data_tx, txn_start, spi_miso,
        input  data_rx, txn_done, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_master.sv
// Byte-level SPI master, mode 0, MSB first. One byte out on MOSI while one byte is captured from MISO.
module spi_master #(
    parameter int HALF_PERIOD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);
    localparam int DW = $clog2(HALF_PERIOD + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_div;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_tx, r_rx, r_data_rx;
    logic          r_done, r_sclk, r_mosi, r_armed;
    logic          w_launch, w_tick, w_finish;

    // armed stops a txn_start held high across completion from relaunching
    assign w_launch = (r_state == IDLE) && bus.txn_start && r_armed;
    assign w_tick   = (r_state == SHIFT) && (r_div == DW'(HALF_PERIOD - 1));
    assign w_finish = w_tick && r_sclk && (r_bit_cnt == 4'd8);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_state_nxt = SHIFT;
            SHIFT:   if (w_finish) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done    <= 1'b1;
            r_data_rx <= 8'h00;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_bit_cnt <= 4'd0;
            r_div     <= '0;
            r_armed   <= 1'b1;
            r_tx      <= 8'h00;
            r_rx      <= 8'h00;
        end else if (r_state == IDLE) begin
            if (w_launch) begin
                r_tx      <= bus.data_tx;
                r_mosi    <= bus.data_tx[7];
                r_done    <= 1'b0;
                r_div     <= '0;
                r_bit_cnt <= 4'd0;
                r_armed   <= 1'b0;
            end else if (!bus.txn_start) begin
                r_armed <= 1'b1;
            end
        end else if (w_tick) begin
            r_div <= '0;
            if (!r_sclk) begin
                r_sclk    <= 1'b1;
                r_rx      <= {r_rx[6:0], bus.spi_miso};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_finish) begin
                r_sclk    <= 1'b0;
                r_data_rx <= r_rx;
                r_done    <= 1'b1;
                r_mosi    <= 1'b0;
            end else begin
                // falling edge: present the next bit for the slave's next rising-edge sample
                r_sclk <= 1'b0;
                r_mosi <= r_tx[6];
                r_tx   <= {r_tx[6:0], 1'b0};
            end
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        bus.data_rx  = r_data_rx;
        bus.txn_done = r_done;
        bus.spi_sclk = r_sclk;
        bus.spi_mosi = r_mosi;
    end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (HALF_PERIOD 2 and 1) driven through a shared initiator/slave model.
module tb_spi_master;
    localparam int HA = 2;
    localparam int HB = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_if ifa ();
    spi_master_if ifb ();

    spi_master #(.HALF_PERIOD(HA)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
    spi_master #(.HALF_PERIOD(HB)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    // sel picks which instance the initiator/slave model is talking to
    logic       sel = 1'b0;
    logic       loop_drv = 1'b0;
    logic       start_drv = 1'b0;
    logic       miso_drv = 1'b0;
    logic [7:0] tx_drv = 8'h00;

    assign ifa.data_tx   = tx_drv;
    assign ifb.data_tx   = tx_drv;
    assign ifa.txn_start = sel ? 1'b0 : start_drv;
    assign ifb.txn_start = sel ? start_drv : 1'b0;
    assign ifa.spi_miso  = loop_drv ? ifa.spi_mosi : miso_drv;
    assign ifb.spi_miso  = loop_drv ? ifb.spi_mosi : miso_drv;

    logic       sclk_m, mosi_m, done_m;
    logic [7:0] rx_m;
    assign sclk_m = sel ? ifb.spi_sclk : ifa.spi_sclk;
    assign mosi_m = sel ? ifb.spi_mosi : ifa.spi_mosi;
    assign done_m = sel ? ifb.txn_done : ifa.txn_done;
    assign rx_m   = sel ? ifb.data_rx  : ifa.data_rx;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] prev_rx [2];

    typedef struct {
        logic       d;
        logic       loop;
        logic [7:0] tx;
        logic [7:0] slv;
        logic [7:0] exp_rx;
        int         exp_low;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // One standard handshake transfer; the slave presents slv MSB first, advancing after each SCLK rise.
    task automatic xfer(input logic d, input logic [7:0] tx, input logic [7:0] slv,
                        input bit hold, input bit mid,
                        output logic [7:0] mseen, output int low, output int rises, output bit fin);
        bit   seen_low;
        logic prev;
        sel = d; tx_drv = tx; miso_drv = slv[7]; start_drv = 1'b0;
        mseen = 8'h00; low = 0; rises = 0; fin = 1'b0; seen_low = 1'b0;
        @(posedge clk); #1;
        prev = sclk_m;
        start_drv = 1'b1;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (!done_m) begin
                low++;
                seen_low = 1'b1;
                if (!hold && low == 1) start_drv = 1'b0;
                if (mid && low == 10) begin tx_drv = 8'h0F; start_drv = 1'b1; end
                if (mid && low == 11) start_drv = 1'b0;
            end
            if (sclk_m && !prev) begin
                mseen = {mseen[6:0], mosi_m};
                rises++;
                if (rises < 8) miso_drv = slv[7-rises];
            end
            prev = sclk_m;
            if (seen_low && done_m) fin = 1'b1;
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v, input bit mid);
        logic [7:0] mseen;
        int low, rises;
        bit fin;
        sel = v.d; loop_drv = v.loop;
        #1;
        chk({nm, ".hold"}, rx_m, prev_rx[v.d]);
        xfer(v.d, v.tx, v.slv, 1'b0, mid, mseen, low, rises, fin);
        chk({nm, ".finish"}, fin, 1);
        chk({nm, ".mosi"}, mseen, v.tx);
        chk({nm, ".rises"}, rises, 8);
        chk({nm, ".done_low"}, low, v.exp_low);
        chk({nm, ".rx"}, rx_m, v.exp_rx);
        chk({nm, ".sclk_idle"}, sclk_m, 0);
        prev_rx[v.d] = v.exp_rx;
    endtask

    initial begin
        vec_t vecs [7];
        vec_t v;
        logic [7:0] mseen;
        int low, rises, cnt;
        bit fin;

        vecs[0] = '{1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5, 16*HA};
        vecs[1] = '{1'b1, 1'b0, 8'h00, 8'h3C, 8'h3C, 16*HB};
        vecs[2] = '{1'b0, 1'b0, 8'h03, 8'hFF, 8'hFF, 16*HA};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 16*HA};
        vecs[4] = '{1'b0, 1'b0, 8'h12, 8'hFF, 8'hFF, 16*HA};
        vecs[5] = '{1'b0, 1'b0, 8'h34, 8'hFF, 8'hFF, 16*HA};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h5A, 8'h5A, 16*HA};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.done_a", ifa.txn_done, 1);
        chk("rst.sclk_a", ifa.spi_sclk, 0);
        chk("rst.mosi_a", ifa.spi_mosi, 0);
        chk("rst.rx_a", ifa.data_rx, 8'h00);
        chk("rst.done_b", ifb.txn_done, 1);
        chk("rst.sclk_b", ifb.spi_sclk, 0);
        chk("rst.mosi_b", ifb.spi_mosi, 0);
        chk("rst.rx_b", ifb.data_rx, 8'h00);
        prev_rx[0] = 8'h00;
        prev_rx[1] = 8'h00;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

        // txn_start held high through completion: exactly one transfer, then a 1-cycle drop relaunches
        sel = 1'b0; loop_drv = 1'b1;
        xfer(1'b0, 8'h66, 8'h00, 1'b1, 1'b0, mseen, low, rises, fin);
        chk("hold.finish", fin, 1);
        chk("hold.rx", rx_m, 8'h66);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (!done_m) cnt++;
        end
        chk("hold.no_relaunch", cnt, 0);
        start_drv = 1'b0;
        @(posedge clk); #1;
        start_drv = 1'b1;
        @(posedge clk); #1;
        chk("hold.relaunch_edge", done_m, 0);
        start_drv = 1'b0;
        cnt = 1;
        for (int c = 0; c < 200 && !done_m; c++) begin
            @(posedge clk); #1;
            if (!done_m) cnt++;
        end
        chk("hold.relaunch_low", cnt, 16*HA);
        chk("hold.relaunch_rx", rx_m, 8'h66);
        prev_rx[0] = 8'h66;

        // reset applied right after the 3rd SCLK rise of a transfer
        sel = 1'b0; loop_drv = 1'b0; tx_drv = 8'h99; miso_drv = 1'b1;
        start_drv = 1'b0;
        @(posedge clk); #1;
        start_drv = 1'b1;
        rises = 0;
        fin = 1'b0;
        begin
            logic prev;
            prev = sclk_m;
            for (int c = 0; c < 200 && !fin; c++) begin
                @(posedge clk); #1;
                if (!done_m) start_drv = 1'b0;
                if (sclk_m && !prev) rises++;
                prev = sclk_m;
                if (rises == 3) fin = 1'b1;
            end
        end
        chk("rst_mid.reached", fin, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid.done", ifa.txn_done, 1);
        chk("rst_mid.sclk", ifa.spi_sclk, 0);
        chk("rst_mid.mosi", ifa.spi_mosi, 0);
        chk("rst_mid.rx", ifa.data_rx, 8'h00);
        rst_n = 1'b1;
        prev_rx[0] = 8'h00;
        prev_rx[1] = 8'h00;
        v = '{1'b0, 1'b0, 8'hC3, 8'h5A, 8'h5A, 16*HA};
        run_vec("after_rst", v, 1'b0);

        // data_tx change and a stray txn_start pulse mid-transfer are both ignored
        v = '{1'b0, 1'b0, 8'hF0, 8'h0F, 8'h0F, 16*HA};
        run_vec("midchg", v, 1'b1);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (!done_m) cnt++;
        end
        chk("midchg.no_retrigger", cnt, 0);

        // random transfers against a byte-level model: rx is the slave byte (or tx in loopback)
        for (int i = 0; i < 20; i++) begin
            v.d       = 1'($urandom_range(0, 1));
            v.loop    = 1'($urandom_range(0, 1));
            v.tx      = 8'($urandom);
            v.slv     = 8'($urandom);
            v.exp_rx  = v.loop ? v.tx : v.slv;
            v.exp_low = 16 * (v.d ? HB : HA);
            run_vec($sformatf("rnd%0d", i), v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
